// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte-enable base patterns and the alignment check.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_ILL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } state_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic logic misaligned(size_e size, logic [1:0] ofs);
      case (size)
         SZ_H:    return ofs[0];
         SZ_W:    return ofs != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side op port, data-memory bus and register-file write port of the LSU.
// slave = LSU view, master = environment (execute stage, memory, RF) view.
interface load_store_unit_if #(
   parameter int Width    = 32,
   parameter int RegAddrW = 5
);
   logic                ls_valid_i;
   logic                ls_ready_o;
   logic                ls_we_i;
   logic [1:0]          ls_size_i;
   logic                ls_unsigned_i;
   logic [Width-1:0]    ls_addr_i;
   logic [Width-1:0]    ls_wdata_i;
   logic [RegAddrW-1:0] ls_rd_i;

   logic                dmem_req_o;
   logic                dmem_gnt_i;
   logic                dmem_we_o;
   logic [3:0]          dmem_be_o;
   logic [Width-1:0]    dmem_addr_o;
   logic [Width-1:0]    dmem_wdata_o;
   logic                dmem_rvalid_i;
   logic [Width-1:0]    dmem_rdata_i;

   logic                wb_we_o;
   logic [RegAddrW-1:0] wb_rd_o;
   logic [Width-1:0]    wb_data_o;
   logic                done_o;
   logic                err_o;
   logic [Width-1:0]    err_addr_o;

   modport slave (
      input  ls_valid_i, ls_we_i, ls_size_i, ls_unsigned_i, ls_addr_i, ls_wdata_i, ls_rd_i,
      output ls_ready_o,
      output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
      output wb_we_o, wb_rd_o, wb_data_o, done_o, err_o, err_addr_o
   );

   modport master (
      output ls_valid_i, ls_we_i, ls_size_i, ls_unsigned_i, ls_addr_i, ls_wdata_i, ls_rd_i,
      input  ls_ready_o,
      input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
      input  wb_we_o, wb_rd_o, wb_data_o, done_o, err_o, err_addr_o
   );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it to the full register width.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic [Width-1:0] rdata,
   input  logic [1:0]       ofs,
   input  size_e            size,
   input  logic             uns,
   output logic [Width-1:0] data
);

   logic [Width-1:0] lane;

   assign lane = rdata >> {ofs, 3'b000};

   always_comb begin
      data = lane;
      case (size)
         SZ_B: data = uns ? {{(Width-8){1'b0}}, lane[7:0]}
                          : {{(Width-8){lane[7]}}, lane[7:0]};
         SZ_H: data = uns ? {{(Width-16){1'b0}}, lane[15:0]}
                          : {{(Width-16){lane[15]}}, lane[15:0]};
         default: data = lane;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store engine between execute and the register-file write port.
// Optional WAIT-state watchdog enabled by defining LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for an op; faulting ops retire from here with err
// REQ   | dmem_req_o held with stable addr/we/be/wdata until grant
// WAIT  | load granted, waiting for rvalid (or watchdog expiry)
// RESP  | one-cycle retire: done_o, plus RF write for loads
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int Width       = 32,
   parameter int RegAddrW    = 5,
   parameter int TimeoutCycs = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   load_store_unit_if.slave  bus
);

   state_e              state_q, state_d;
   logic                we_q, uns_q;
   size_e               size_q;
   logic [Width-1:0]    addr_q, wdata_q;
   logic [RegAddrW-1:0] rd_q;
   logic [3:0]          be_q;
   logic                err_pend_q, err_set;
   logic [Width-1:0]    err_addr_q;
   logic [Width-1:0]    wb_data_q;
   logic [RegAddrW-1:0] wb_rd_q;
   logic [Width-1:0]    align_data;
   logic                accept, bad_op, tmo_hit;
   size_e               size_in;
   logic [3:0]          be_in;
   logic [Width-1:0]    wdata_in;

   assign size_in = size_e'(bus.ls_size_i);
   assign accept  = bus.ls_valid_i && (state_q == IDLE);
   assign bad_op  = (size_in == SZ_ILL) || misaligned(size_in, bus.ls_addr_i[1:0]);

   always_comb begin
      be_in    = BE_WORD;
      wdata_in = bus.ls_wdata_i;
      case (size_in)
         SZ_B: begin
            be_in    = BE_BYTE << bus.ls_addr_i[1:0];
            wdata_in = {(Width/8){bus.ls_wdata_i[7:0]}};
         end
         SZ_H: begin
            be_in    = BE_HALF << bus.ls_addr_i[1:0];
            wdata_in = {(Width/16){bus.ls_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   // Reloaded while requesting so the first WAIT cycle sees TimeoutCycs-1.
   logic [7:0] tmo_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= 8'd0;
      end else if (state_q == REQ) begin
         tmo_cnt_q <= 8'(TimeoutCycs - 1);
      end else if (state_q == WAIT && tmo_cnt_q != 8'd0) begin
         tmo_cnt_q <= tmo_cnt_q - 8'd1;
      end
   end

   assign tmo_hit = (tmo_cnt_q == 8'd0);
`else
   // Constant false: without the watchdog a load waits for rvalid indefinitely.
   assign tmo_hit = (TimeoutCycs < 0);
`endif

   always_comb begin
      state_d = state_q;
      err_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bad_op) err_set = 1'b1;
               else        state_d = REQ;
            end
         end
         REQ: begin
            if (bus.dmem_gnt_i) state_d = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (bus.dmem_rvalid_i) begin
               state_d = RESP;
            end else if (tmo_hit) begin
               err_set = 1'b1;
               state_d = IDLE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= SZ_B;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         be_q       <= '0;
         err_pend_q <= 1'b0;
         err_addr_q <= '0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
      end else begin
         state_q    <= state_d;
         err_pend_q <= err_set;
         if (accept) begin
            we_q    <= bus.ls_we_i;
            uns_q   <= bus.ls_unsigned_i;
            size_q  <= size_in;
            addr_q  <= bus.ls_addr_i;
            wdata_q <= wdata_in;
            rd_q    <= bus.ls_rd_i;
            be_q    <= be_in;
         end
         if (err_set) err_addr_q <= (state_q == IDLE) ? bus.ls_addr_i : addr_q;
         if (state_q == WAIT && bus.dmem_rvalid_i) begin
            wb_data_q <= align_data;
            wb_rd_q   <= rd_q;
         end
      end
   end

   lsu_load_align #(.Width(Width)) u_load_align (
      .rdata (bus.dmem_rdata_i),
      .ofs   (addr_q[1:0]),
      .size  (size_q),
      .uns   (uns_q),
      .data  (align_data)
   );

   // Bus outputs are forced to zero outside REQ so idle/reset values are clean.
   assign bus.ls_ready_o   = (state_q == IDLE);
   assign bus.dmem_req_o   = (state_q == REQ);
   assign bus.dmem_we_o    = (state_q == REQ) && we_q;
   assign bus.dmem_be_o    = (state_q == REQ) ? be_q : 4'b0000;
   assign bus.dmem_addr_o  = (state_q == REQ) ? {addr_q[Width-1:2], 2'b00} : '0;
   assign bus.dmem_wdata_o = (state_q == REQ) ? wdata_q : '0;

   assign bus.wb_we_o    = (state_q == RESP) && !we_q && (rd_q != '0);
   assign bus.wb_rd_o    = wb_rd_q;
   assign bus.wb_data_o  = wb_data_q;
   assign bus.done_o     = (state_q == RESP) || err_pend_q;
   assign bus.err_o      = err_pend_q;
   assign bus.err_addr_o = err_addr_q;

endmodule
